// File: rtl/reg_bank_pkg.sv
// Shared constants, FSM encoding and helpers for the register bank and its neighbours.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_bank_pkg;

    // Defaults shared with decode and writeback so the whole datapath agrees on sizes
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;

    // Init sweep FSM encoding
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Ceiling log2, minimum 1 bit so a 2-entry bank still gets an address line
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_bank_init_seq.sv
// Init sweep FSM: writes reg[i] = i*INIT_STEP for every entry, then raises READY.
// Latency: NUM_REGS cycles per sweep, READY registered and high the cycle after the last write.
// Backpressure: none; INIT_REQ is only honoured in RUN, ignored mid-sweep.
module reg_bank_init_seq
    import reg_bank_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int INIT_STEP = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_init_req,
    output logic              o_init_we,
    output logic [ADDR_W-1:0] o_init_addr,
    output logic [DATA_W-1:0] o_init_data,
    output logic              o_ready
);

    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(NUM_REGS - 1);
    localparam logic [DATA_W-1:0] LP_STEP = DATA_W'(INIT_STEP);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_ready;

    // Sweep FSM: walk the counter through every register, then sit in RUN until a re-init request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_cnt == LP_LAST) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (i_init_req) begin
                        r_state <= ST_INIT;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_init_we   = (r_state == ST_INIT);
    assign o_init_addr = r_cnt;
    // Product wraps modulo 2^DATA_W by construction
    assign o_init_data = DATA_W'(r_cnt) * LP_STEP;
    assign o_ready     = r_ready;

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-read-port register file with hardware init sweep, optional zero reg and write bypass.
// Latency: reads combinational; writes visible next cycle (same cycle with BYPASS); WRT_DROP one cycle after.
// Backpressure: READY low during the sweep; writes offered then are discarded and flagged on WRT_DROP.
module reg_bank_mp
    import reg_bank_pkg::*;
#(
    parameter int   DATA_W    = DEF_DATA_W,
    parameter int   NUM_REGS  = DEF_NUM_REGS,
    parameter int   NUM_RD    = 2,
    parameter int   INIT_STEP = 10,
    parameter bit   ZERO_REG  = 1'b1,
    parameter bit   BYPASS    = 1'b1,
    localparam int  ADDR_W    = clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     INIT_REQ,
    input  logic [NUM_RD*ADDR_W-1:0] SRC_REG,
    output logic [NUM_RD*DATA_W-1:0] REG_DATA,
    input  logic [ADDR_W-1:0]        DEST_REG,
    input  logic [DATA_W-1:0]        WRT_DATA,
    input  logic                     WRT_EN,
    output logic                     READY,
    output logic                     WRT_DROP
);

    // One bit wider than the address so NUM_REGS itself is representable
    localparam logic [ADDR_W:0] LP_NUM = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0] r_mem [NUM_REGS];
    logic              r_wrt_drop;

    logic              w_ready;
    logic              w_seq_we;
    logic              w_init_we;
    logic [ADDR_W-1:0] w_init_addr;
    logic [DATA_W-1:0] w_init_data;
    logic              w_dest_ok;
    logic              w_dest_zero;
    logic              w_user_we;

    reg_bank_init_seq #(
        .DATA_W    (DATA_W),
        .NUM_REGS  (NUM_REGS),
        .ADDR_W    (ADDR_W),
        .INIT_STEP (INIT_STEP)
    ) u_init_seq (
        .clk         (clk),
        .rst         (rst),
        .i_init_req  (INIT_REQ),
        .o_init_we   (w_seq_we),
        .o_init_addr (w_init_addr),
        .o_init_data (w_init_data),
        .o_ready     (w_ready)
    );

    // Hold off sweep writes while reset is asserted so reg 0 is not rewritten on every clock
    assign w_init_we   = w_seq_we & rst;
    assign w_dest_ok   = ({1'b0, DEST_REG} < LP_NUM);
    assign w_dest_zero = ZERO_REG && (DEST_REG == '0);
    assign w_user_we   = WRT_EN & w_ready & w_dest_ok & ~w_dest_zero;

    // Array update: sweep and user writes never overlap because user writes need READY
    always_ff @(posedge clk) begin
        if (w_init_we) begin
            r_mem[w_init_addr] <= w_init_data;
        end else if (w_user_we) begin
            r_mem[DEST_REG] <= WRT_DATA;
        end
    end

    // Flag any offered write that did not commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrt_drop <= 1'b0;
        end else begin
            r_wrt_drop <= WRT_EN & ~w_user_we;
        end
    end

    assign READY    = w_ready;
    assign WRT_DROP = r_wrt_drop;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_raddr;
        logic              w_rd_ok;
        logic              w_byp;
        logic [DATA_W-1:0] w_rdata;

        assign w_raddr = SRC_REG[k*ADDR_W +: ADDR_W];
        assign w_rd_ok = w_ready && ({1'b0, w_raddr} < LP_NUM) && !(ZERO_REG && (w_raddr == '0));
        // w_user_we already excludes out-of-range and zero-reg targets
        assign w_byp   = BYPASS && w_user_we && (DEST_REG == w_raddr);

        // Read mux: zero when not ready/invalid, forwarded write data on a hit, else array
        always_comb begin
            w_rdata = '0;
            if (w_rd_ok) begin
                w_rdata = w_byp ? WRT_DATA : r_mem[w_raddr];
            end
        end

        assign REG_DATA[k*DATA_W +: DATA_W] = w_rdata;
    end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed bench for two bank configurations sharing one stimulus stream.
// Expectations are queued at drive time and checked by a monitor on the falling edge.
// u_a: 32 regs, zero reg + bypass; u_b: 18 regs, no zero reg, no bypass.
module tb_reg_bank_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_req;
    logic [9:0]  src;
    logic [4:0]  dest;
    logic [31:0] wdata;
    logic        wen;

    logic [63:0] a_data, b_data;
    logic        a_ready, b_ready, a_drop, b_drop;

    int exp_kind[$];
    logic [31:0] exp_val[$];
    string exp_name[$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_bank_mp u_a (
        .clk      (clk),
        .rst      (rst),
        .INIT_REQ (init_req),
        .SRC_REG  (src),
        .REG_DATA (a_data),
        .DEST_REG (dest),
        .WRT_DATA (wdata),
        .WRT_EN   (wen),
        .READY    (a_ready),
        .WRT_DROP (a_drop)
    );

    reg_bank_mp #(
        .NUM_REGS (18),
        .ZERO_REG (1'b0),
        .BYPASS   (1'b0)
    ) u_b (
        .clk      (clk),
        .rst      (rst),
        .INIT_REQ (init_req),
        .SRC_REG  (src),
        .REG_DATA (b_data),
        .DEST_REG (dest),
        .WRT_DATA (wdata),
        .WRT_EN   (wen),
        .READY    (b_ready),
        .WRT_DROP (b_drop)
    );

    // kind = dut*4 + {0: read port 0, 1: read port 1, 2: READY, 3: WRT_DROP}
    function automatic logic [31:0] actual(input int kind);
        logic [31:0] r;
        case (kind)
            0:       r = a_data[31:0];
            1:       r = a_data[63:32];
            2:       r = {31'b0, a_ready};
            3:       r = {31'b0, a_drop};
            4:       r = b_data[31:0];
            5:       r = b_data[63:32];
            6:       r = {31'b0, b_ready};
            7:       r = {31'b0, b_drop};
            default: r = 'x;
        endcase
        return r;
    endfunction

    task automatic push(input int kind, input logic [31:0] val, input string name);
        exp_kind.push_back(kind);
        exp_val.push_back(val);
        exp_name.push_back(name);
    endtask

    task automatic exp_rd(input int dut, input logic [31:0] e0, input logic [31:0] e1, input string tag);
        string d;
        d = (dut == 0) ? "A" : "B";
        push(dut*4 + 0, e0, $sformatf("%s_%s_rd0", d, tag));
        push(dut*4 + 1, e1, $sformatf("%s_%s_rd1", d, tag));
    endtask

    task automatic exp_st(input int dut, input logic rdy, input logic drop, input string tag);
        string d;
        d = (dut == 0) ? "A" : "B";
        push(dut*4 + 2, {31'b0, rdy},  $sformatf("%s_%s_ready", d, tag));
        push(dut*4 + 3, {31'b0, drop}, $sformatf("%s_%s_drop", d, tag));
    endtask

    // Advance to just after the next rising edge and apply a new input vector
    task automatic drive(input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] d,
                         input logic [31:0] wd, input logic we, input logic ir);
        @(posedge clk);
        #1;
        src      = {s1, s0};
        dest     = d;
        wdata    = wd;
        wen      = we;
        init_req = ir;
    endtask

    // Caller is already in the cycle where the sweep counter is 0 (i=0).
    // After i edges the counter is i; READY rises once NUM_REGS edges have passed.
    task automatic sweep(input logic [31:0] ea0, input logic [31:0] ea1,
                         input logic [31:0] eb0, input logic [31:0] eb1,
                         input logic drop1, input string tag);
        for (int i = 0; i <= 40; i++) begin
            string t;
            if (i > 0) drive(src[4:0], src[9:5], 5'd0, 32'd0, 1'b0, 1'b0);
            t = $sformatf("%s%0d", tag, i);
            exp_st(0, (i >= 32), (i == 1) ? drop1 : 1'b0, t);
            exp_st(1, (i >= 18), (i == 1) ? drop1 : 1'b0, t);
            exp_rd(0, (i >= 32) ? ea0 : 32'd0, (i >= 32) ? ea1 : 32'd0, t);
            exp_rd(1, (i >= 18) ? eb0 : 32'd0, (i >= 18) ? eb1 : 32'd0, t);
        end
    endtask

    // Monitor: drain every expectation queued for this cycle, away from the rising edge
    always @(negedge clk) begin
        while (exp_kind.size() > 0) begin
            int          k;
            logic [31:0] e;
            logic [31:0] a;
            string       n;
            k = exp_kind.pop_front();
            e = exp_val.pop_front();
            n = exp_name.pop_front();
            a = actual(k);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h", n, a, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        init_req = 1'b0;
        src      = '0;
        dest     = '0;
        wdata    = '0;
        wen      = 1'b0;
        #1;
        exp_st(0, 1'b0, 1'b0, "rst");
        exp_st(1, 1'b0, 1'b0, "rst");
        exp_rd(0, 32'd0, 32'd0, "rst");
        exp_rd(1, 32'd0, 32'd0, "rst");
        repeat (3) @(posedge clk);

        // Boot sweep; reg 31 is out of range for the 18-entry bank
        drive(5'd5, 5'd31, 5'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        sweep(32'd50, 32'd310, 32'd50, 32'd0, 1'b0, "boot");

        drive(5'd5, 5'd31, 5'd0, 32'd0, 1'b0, 1'b0);
        exp_rd(0, 32'd50, 32'd310, "c1");
        exp_rd(1, 32'd50, 32'd0, "c1");

        drive(5'd0, 5'd17, 5'd0, 32'd0, 1'b0, 1'b0);
        exp_rd(0, 32'd0, 32'd170, "c2");
        exp_rd(1, 32'd0, 32'd170, "c2");

        // Write reg3: bypassed on A only
        drive(5'd3, 5'd4, 5'd3, 32'hDEADBEEF, 1'b1, 1'b0);
        exp_rd(0, 32'hDEADBEEF, 32'd40, "byp");
        exp_rd(1, 32'd30, 32'd40, "byp");

        drive(5'd3, 5'd4, 5'd0, 32'd0, 1'b0, 1'b0);
        exp_rd(0, 32'hDEADBEEF, 32'd40, "byp_nx");
        exp_rd(1, 32'hDEADBEEF, 32'd40, "byp_nx");
        exp_st(0, 1'b1, 1'b0, "byp_nx");
        exp_st(1, 1'b1, 1'b0, "byp_nx");

        // Write reg0: refused on A (zero reg), accepted on B
        drive(5'd0, 5'd3, 5'd0, 32'h1234, 1'b1, 1'b0);
        exp_rd(0, 32'd0, 32'hDEADBEEF, "z0");
        exp_rd(1, 32'd0, 32'hDEADBEEF, "z0");

        drive(5'd0, 5'd3, 5'd0, 32'd0, 1'b0, 1'b0);
        exp_rd(0, 32'd0, 32'hDEADBEEF, "z0_nx");
        exp_rd(1, 32'h1234, 32'hDEADBEEF, "z0_nx");
        exp_st(0, 1'b1, 1'b1, "z0_nx");
        exp_st(1, 1'b1, 1'b0, "z0_nx");

        drive(5'd0, 5'd3, 5'd0, 32'd0, 1'b0, 1'b0);
        exp_st(0, 1'b1, 1'b0, "z0_end");
        exp_st(1, 1'b1, 1'b0, "z0_end");

        // Write reg20: valid on A, out of range on B
        drive(5'd20, 5'd17, 5'd20, 32'hCAFEF00D, 1'b1, 1'b0);
        exp_rd(0, 32'hCAFEF00D, 32'd170, "oor");
        exp_rd(1, 32'd0, 32'd170, "oor");

        drive(5'd20, 5'd4, 5'd0, 32'd0, 1'b0, 1'b0);
        exp_rd(0, 32'hCAFEF00D, 32'd40, "oor_nx");
        exp_rd(1, 32'd0, 32'd40, "oor_nx");
        exp_st(0, 1'b1, 1'b0, "oor_nx");
        exp_st(1, 1'b1, 1'b1, "oor_nx");

        // reg7 = 7, then re-init with a write in the request cycle, then a write mid-sweep
        drive(5'd7, 5'd8, 5'd7, 32'd7, 1'b1, 1'b0);
        exp_rd(0, 32'd7, 32'd80, "w7");
        exp_rd(1, 32'd70, 32'd80, "w7");

        drive(5'd7, 5'd8, 5'd8, 32'h88, 1'b1, 1'b1);
        exp_rd(0, 32'd7, 32'h88, "req");
        exp_rd(1, 32'd7, 32'd80, "req");
        exp_st(0, 1'b1, 1'b0, "req");
        exp_st(1, 1'b1, 1'b0, "req");

        drive(5'd7, 5'd8, 5'd9, 32'h99, 1'b1, 1'b0);
        sweep(32'd70, 32'd80, 32'd70, 32'd80, 1'b1, "reinit");

        // Re-init, then reset when the sweep counter reaches 10
        drive(5'd5, 5'd31, 5'd0, 32'd0, 1'b0, 1'b1);
        exp_st(0, 1'b1, 1'b0, "req2");
        exp_st(1, 1'b1, 1'b0, "req2");
        drive(5'd5, 5'd31, 5'd0, 32'd0, 1'b0, 1'b0);
        repeat (10) drive(5'd5, 5'd31, 5'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b0;
        exp_st(0, 1'b0, 1'b0, "midrst");
        exp_st(1, 1'b0, 1'b0, "midrst");
        drive(5'd5, 5'd31, 5'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        sweep(32'd50, 32'd310, 32'd50, 32'd0, 1'b0, "rst2");

        // Asynchronous reset from RUN: READY and reads drop without waiting for an edge
        drive(5'd5, 5'd31, 5'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b0;
        exp_st(0, 1'b0, 1'b0, "arst");
        exp_st(1, 1'b0, 1'b0, "arst");
        exp_rd(0, 32'd0, 32'd0, "arst");
        exp_rd(1, 32'd0, 32'd0, "arst");

        @(negedge clk);
        #1;
        if (exp_kind.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_kind.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
